// File: rtl/simple_spi_seq.sv
// Wishbone master that walks one simple_spi core through a complete multi-byte SPI transaction:
// configure, select, stream bytes through SPDR with SPSR polling, deselect, disable.
module simple_spi_seq #(
   parameter int unsigned SS_WIDTH = 1,
   parameter int unsigned LEN_W    = 8,
   parameter int unsigned POLL_MAX = 1023
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [LEN_W-1:0]    req_len_i,
   input  logic                req_cpol_i,
   input  logic                req_cpha_i,
   input  logic [3:0]          req_div_i,
   input  logic [SS_WIDTH-1:0] req_ss_i,
   input  logic                tx_valid_i,
   input  logic [7:0]          tx_data_i,
   output logic                tx_ready_o,
   output logic                rx_valid_o,
   output logic [7:0]          rx_data_o,
   input  logic                rx_ready_i,
   output logic                done_o,
   output logic                err_o,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   output logic [2:0]          wb_adr_o,
   output logic                wb_we_o,
   output logic [7:0]          wb_dat_o,
   input  logic [7:0]          wb_dat_i,
   input  logic                wb_ack_i
);

   localparam int unsigned PW = $clog2(POLL_MAX + 1);

   localparam logic [2:0] A_SPCR = 3'd0;
   localparam logic [2:0] A_SPSR = 3'd1;
   localparam logic [2:0] A_SPDR = 3'd2;
   localparam logic [2:0] A_SPER = 3'd3;
   localparam logic [2:0] A_SS   = 3'd4;

   typedef enum logic [3:0] {
      S_IDLE, S_W_SPCR, S_W_SPER, S_W_SS, S_GET_TX, S_W_SPDR,
      S_POLL, S_R_SPDR, S_PUT_RX, S_W_SSOFF, S_W_OFF, S_DONE
   } state_t;

   typedef struct packed {
      logic       we;
      logic [2:0] adr;
      logic [7:0] dat;
   } wb_req_t;

   state_t                state, nxt;
   wb_req_t               acc_c;
   logic                  issue_c, poll_again_c, poll_to_c;
   logic                  req_acc_c, tx_acc_c, rx_acc_c, ack_c;
   logic                  acked, spsr_empty, err_flag;
   logic [LEN_W-1:0]      cnt;
   logic [PW-1:0]         poll_cnt;
   logic [3:0]            div_q;
   logic [SS_WIDTH-1:0]   ss_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= S_IDLE;
      else         state <= nxt;
   end

   // Each WB state issues on entry, waits for ack, then spends one idle cycle (acked=1) before moving on.
   always_comb begin
      nxt          = state;
      issue_c      = 1'b0;
      poll_again_c = 1'b0;
      poll_to_c    = 1'b0;
      req_acc_c    = req_valid_i && req_ready_o;
      tx_acc_c     = tx_valid_i && tx_ready_o;
      rx_acc_c     = rx_valid_o && rx_ready_i;
      ack_c        = wb_cyc_o && wb_ack_i;
      case (state)
         S_IDLE:   if (req_acc_c) begin nxt = S_W_SPCR; issue_c = 1'b1; end
         S_W_SPCR: if (acked) begin nxt = S_W_SPER; issue_c = 1'b1; end
         S_W_SPER: if (acked) begin nxt = S_W_SS; issue_c = 1'b1; end
         S_W_SS: if (acked) begin
            if (cnt == '0) begin nxt = S_W_SSOFF; issue_c = 1'b1; end
            else           nxt = S_GET_TX;
         end
         S_GET_TX: if (tx_acc_c) begin nxt = S_W_SPDR; issue_c = 1'b1; end
         S_W_SPDR: if (acked) begin nxt = S_POLL; issue_c = 1'b1; end
         S_POLL: if (acked) begin
            issue_c = 1'b1;
            if (!spsr_empty) begin
               nxt = S_R_SPDR;
            end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
               poll_to_c = 1'b1;
               nxt       = S_W_SSOFF;
            end else begin
               poll_again_c = 1'b1;
            end
         end
         S_R_SPDR: if (acked) nxt = S_PUT_RX;
         S_PUT_RX: if (rx_acc_c) begin
            if (cnt == LEN_W'(1)) begin nxt = S_W_SSOFF; issue_c = 1'b1; end
            else                  nxt = S_GET_TX;
         end
         S_W_SSOFF: if (acked) begin nxt = S_W_OFF; issue_c = 1'b1; end
         S_W_OFF:   if (acked) nxt = S_DONE;
         S_DONE:    nxt = S_IDLE;
         default:   nxt = S_IDLE;
      endcase

      // SPCR config comes straight from the request and SPDR data from the TX port: both issue on their handshake
      acc_c = '{we: 1'b1, adr: A_SPCR, dat: 8'h00};
      case (nxt)
         S_W_SPCR:  acc_c.dat = {4'b0101, req_cpol_i, req_cpha_i, req_div_i[1:0]};
         S_W_SPER:  begin acc_c.adr = A_SPER; acc_c.dat = {6'b0, div_q[3:2]}; end
         S_W_SS:    begin acc_c.adr = A_SS;   acc_c.dat = 8'(ss_q); end
         S_W_SPDR:  begin acc_c.adr = A_SPDR; acc_c.dat = tx_data_i; end
         S_POLL:    begin acc_c.we = 1'b0; acc_c.adr = A_SPSR; end
         S_R_SPDR:  begin acc_c.we = 1'b0; acc_c.adr = A_SPDR; end
         S_W_SSOFF: acc_c.adr = A_SS;
         default:   acc_c.adr = A_SPCR;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         req_ready_o <= 1'b0;
         tx_ready_o  <= 1'b0;
         rx_valid_o  <= 1'b0;
         rx_data_o   <= 8'h00;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_adr_o    <= 3'd0;
         wb_we_o     <= 1'b0;
         wb_dat_o    <= 8'h00;
         acked       <= 1'b0;
         spsr_empty  <= 1'b0;
         err_flag    <= 1'b0;
         cnt         <= '0;
         poll_cnt    <= '0;
         div_q       <= 4'h0;
         ss_q        <= '0;
      end else begin
         req_ready_o <= (nxt == S_IDLE);
         tx_ready_o  <= (nxt == S_GET_TX);
         rx_valid_o  <= (nxt == S_PUT_RX);
         done_o      <= (nxt == S_DONE);
         err_o       <= (nxt == S_DONE) && err_flag;

         if (req_acc_c) begin
            div_q    <= req_div_i;
            ss_q     <= req_ss_i;
            cnt      <= req_len_i;
            poll_cnt <= '0;
         end

         if (issue_c) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= acc_c.we;
            wb_adr_o <= acc_c.adr;
            wb_dat_o <= acc_c.dat;
            acked    <= 1'b0;
         end else if (ack_c) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            acked    <= 1'b1;
         end

         if (ack_c && state == S_POLL)   spsr_empty <= wb_dat_i[0];
         if (ack_c && state == S_R_SPDR) rx_data_o  <= wb_dat_i;

         if (poll_again_c) poll_cnt <= poll_cnt + PW'(1);

         if (poll_to_c)            err_flag <= 1'b1;
         else if (state == S_DONE) err_flag <= 1'b0;

         if (rx_acc_c) begin
            cnt      <= cnt - LEN_W'(1);
            poll_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_simple_spi_seq.sv
// Directed bench for simple_spi_seq: a small simple_spi register model on the WB side,
// byte-stream drivers on the host side, and a bus-protocol monitor.
module tb_simple_spi_seq;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       req_valid = 1'b0, req_ready;
   logic [7:0] req_len = 8'd0;
   logic       req_cpol = 1'b0, req_cpha = 1'b0;
   logic [3:0] req_div = 4'h0;
   logic [0:0] req_ss = 1'b0;
   logic       tx_valid = 1'b0, tx_ready;
   logic [7:0] tx_data = 8'h00;
   logic       rx_valid, rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       done, err;
   logic       wb_cyc, wb_stb, wb_we;
   logic [2:0] wb_adr;
   logic [7:0] wb_dat_o;
   logic [7:0] s_rdat = 8'h00;
   logic       s_ack = 1'b0;

   int checks = 0;
   int failures = 0;

   simple_spi_seq #(.SS_WIDTH(1), .LEN_W(8), .POLL_MAX(8)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_len_i(req_len),
      .req_cpol_i(req_cpol), .req_cpha_i(req_cpha), .req_div_i(req_div), .req_ss_i(req_ss),
      .tx_valid_i(tx_valid), .tx_data_i(tx_data), .tx_ready_o(tx_ready),
      .rx_valid_o(rx_valid), .rx_data_o(rx_data), .rx_ready_i(rx_ready),
      .done_o(done), .err_o(err),
      .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_adr_o(wb_adr), .wb_we_o(wb_we),
      .wb_dat_o(wb_dat_o), .wb_dat_i(s_rdat), .wb_ack_i(s_ack)
   );

   always #5 clk = ~clk;

   // simple_spi register model: echo or loopback SPDR, SPSR.RFEMPTY set for one poll after each SPDR write
   logic       loop_mode = 1'b0, stuck = 1'b0;
   logic [7:0] echo_val = 8'h00;
   int         ack_dly = 0;
   int         s_wait = 0, s_polls = 0;
   logic [7:0] s_rx = 8'h00;
   logic [10:0] wr_log [256];
   int         wr_n = 0, rd1_n = 0, rd2_n = 0;

   always @(posedge clk) begin
      s_ack <= 1'b0;
      if (wb_cyc && wb_stb && !s_ack) begin
         if (s_wait < ack_dly) begin
            s_wait <= s_wait + 1;
         end else begin
            s_wait <= 0;
            s_ack  <= 1'b1;
            if (wb_we) begin
               wr_log[wr_n & 255] <= {wb_adr, wb_dat_o};
               wr_n <= wr_n + 1;
               if (wb_adr == 3'd2) begin
                  s_rx    <= loop_mode ? wb_dat_o : echo_val;
                  s_polls <= 1;
               end
            end else if (wb_adr == 3'd1) begin
               s_rdat <= {7'b0, (stuck || s_polls != 0)};
               if (s_polls != 0) s_polls <= s_polls - 1;
               rd1_n <= rd1_n + 1;
            end else begin
               s_rdat <= s_rx;
               if (wb_adr == 3'd2) rd2_n <= rd2_n + 1;
            end
         end
      end
   end

   // Bus monitor: signals held until ack, and at least one idle cycle after every ack
   logic       p_cyc = 1'b0, p_ack = 1'b0, p_we = 1'b0;
   logic [2:0] p_adr = 3'd0;
   logic [7:0] p_dat = 8'h00;
   int         stab_err = 0, b2b_err = 0;

   always @(negedge clk) begin
      if (rstn && p_cyc && !p_ack &&
          (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || wb_adr !== p_adr || wb_we !== p_we || wb_dat_o !== p_dat))
         stab_err <= stab_err + 1;
      if (rstn && p_cyc && p_ack && wb_cyc) b2b_err <= b2b_err + 1;
      p_cyc <= rstn ? wb_cyc : 1'b0;
      p_ack <= s_ack;
      p_adr <= wb_adr;
      p_we  <= wb_we;
      p_dat <= wb_dat_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   localparam int LIMIT = 4000;
   logic [7:0]  txv [8];
   logic [7:0]  rxv [8];
   logic [10:0] ew  [16];
   logic        d_err = 1'b0;

   task automatic send_req(input logic [7:0] len, input logic cpol, input logic cpha,
                           input logic [3:0] div, input logic ss);
      int k = 0;
      req_len = len; req_cpol = cpol; req_cpha = cpha; req_div = div; req_ss = ss;
      req_valid = 1'b1;
      while (req_ready !== 1'b1 && k < LIMIT) begin @(negedge clk); k++; end
      check("req_ready_wait", 32'(req_ready), 32'd1);
      @(posedge clk); #1 req_valid = 1'b0;
   endtask

   task automatic tx_feed(input int n, input int dly);
      for (int i = 0; i < n; i++) begin
         int k = 0;
         while (tx_ready !== 1'b1 && k < LIMIT) begin @(negedge clk); k++; end
         check("tx_ready_wait", 32'(tx_ready), 32'd1);
         if (k >= LIMIT) return;
         repeat (dly) @(negedge clk);
         tx_valid = 1'b1; tx_data = txv[i];
         @(posedge clk); #1 tx_valid = 1'b0;
      end
   endtask

   task automatic rx_take(input int n, input int dly);
      for (int i = 0; i < n; i++) begin
         int k = 0;
         logic [7:0] first;
         while (rx_valid !== 1'b1 && k < LIMIT) begin @(negedge clk); k++; end
         check("rx_valid_wait", 32'(rx_valid), 32'd1);
         if (k >= LIMIT) return;
         first = rx_data;
         for (int d = 0; d < dly; d++) begin
            @(negedge clk);
            check("rx_hold_valid", 32'(rx_valid), 32'd1);
            check("rx_hold_data", 32'(rx_data), 32'(first));
         end
         rx_ready = 1'b1;
         @(posedge clk); #1 rx_ready = 1'b0;
         rxv[i] = first;
      end
   endtask

   task automatic wait_done();
      int k = 0;
      while (done !== 1'b1 && k < LIMIT) begin @(negedge clk); k++; end
      check("done_seen", 32'(done), 32'd1);
      d_err = err;
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   task automatic check_writes(input string tag, input int base, input int n);
      check({tag, "_wr_count"}, 32'(wr_n - base), 32'(n));
      for (int i = 0; i < n && i < 16; i++)
         check($sformatf("%s_wr%0d", tag, i), 32'(wr_log[(base + i) & 255]), 32'(ew[i]));
   endtask

   int base, b1, b2;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_outputs", 32'({wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, req_ready, tx_ready,
                                rx_valid, rx_data, done, err}), 32'd0);
      #2 rstn = 1'b1;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);

      // T1: single byte, echo 0x3C
      echo_val = 8'h3C; loop_mode = 1'b0;
      base = wr_n; b1 = rd1_n; b2 = rd2_n;
      txv[0] = 8'hA5;
      send_req(8'd1, 1'b0, 1'b0, 4'h0, 1'b1);
      fork tx_feed(1, 0); rx_take(1, 0); wait_done(); join
      ew[0] = {3'd0, 8'h50}; ew[1] = {3'd3, 8'h00}; ew[2] = {3'd4, 8'h01};
      ew[3] = {3'd2, 8'hA5}; ew[4] = {3'd4, 8'h00}; ew[5] = {3'd0, 8'h00};
      check_writes("t1", base, 6);
      check("t1_spsr_polled", 32'(rd1_n - b1 > 0), 32'd1);
      check("t1_spdr_reads", 32'(rd2_n - b2), 32'd1);
      check("t1_rx", 32'(rxv[0]), 32'h3C);
      check("t1_err", 32'(d_err), 32'd0);

      // T2: four bytes in loopback, cpol/cpha set, divider 0xB
      loop_mode = 1'b1;
      base = wr_n; b2 = rd2_n;
      for (int i = 0; i < 4; i++) txv[i] = 8'(i + 1);
      send_req(8'd4, 1'b1, 1'b1, 4'hB, 1'b1);
      fork tx_feed(4, 0); rx_take(4, 0); wait_done(); join
      ew[0] = {3'd0, 8'h5F}; ew[1] = {3'd3, 8'h02}; ew[2] = {3'd4, 8'h01};
      ew[3] = {3'd2, 8'h01}; ew[4] = {3'd2, 8'h02}; ew[5] = {3'd2, 8'h03};
      ew[6] = {3'd2, 8'h04}; ew[7] = {3'd4, 8'h00}; ew[8] = {3'd0, 8'h00};
      check_writes("t2", base, 9);
      check("t2_spdr_reads", 32'(rd2_n - b2), 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("t2_rx%0d", i), 32'(rxv[i]), 32'(i + 1));
      check("t2_err", 32'(d_err), 32'd0);

      // T3: zero-length request only pulses SS
      base = wr_n; b1 = rd1_n; b2 = rd2_n;
      send_req(8'd0, 1'b0, 1'b0, 4'h0, 1'b1);
      wait_done();
      ew[0] = {3'd0, 8'h50}; ew[1] = {3'd3, 8'h00}; ew[2] = {3'd4, 8'h01};
      ew[3] = {3'd4, 8'h00}; ew[4] = {3'd0, 8'h00};
      check_writes("t3", base, 5);
      check("t3_no_reads", 32'((rd1_n - b1) + (rd2_n - b2)), 32'd0);
      check("t3_err", 32'(d_err), 32'd0);

      // T4: SPSR never ready -> timeout after POLL_MAX=8 reads
      stuck = 1'b1;
      base = wr_n; b1 = rd1_n; b2 = rd2_n;
      txv[0] = 8'h77;
      send_req(8'd1, 1'b0, 1'b0, 4'h5, 1'b1);
      fork tx_feed(1, 0); wait_done(); join
      ew[0] = {3'd0, 8'h51}; ew[1] = {3'd3, 8'h01}; ew[2] = {3'd4, 8'h01};
      ew[3] = {3'd2, 8'h77}; ew[4] = {3'd4, 8'h00}; ew[5] = {3'd0, 8'h00};
      check_writes("t4", base, 6);
      check("t4_spsr_reads", 32'(rd1_n - b1), 32'd8);
      check("t4_spdr_reads", 32'(rd2_n - b2), 32'd0);
      check("t4_err_with_done", 32'(d_err), 32'd1);
      stuck = 1'b0;

      // T5: backpressure on all three interfaces
      ack_dly = 2;
      base = wr_n; b2 = rd2_n;
      txv[0] = 8'h5A; txv[1] = 8'hC3;
      send_req(8'd2, 1'b0, 1'b0, 4'h0, 1'b1);
      fork tx_feed(2, 3); rx_take(2, 5); wait_done(); join
      ew[0] = {3'd0, 8'h50}; ew[1] = {3'd3, 8'h00}; ew[2] = {3'd4, 8'h01};
      ew[3] = {3'd2, 8'h5A}; ew[4] = {3'd2, 8'hC3}; ew[5] = {3'd4, 8'h00};
      ew[6] = {3'd0, 8'h00};
      check_writes("t5", base, 7);
      check("t5_spdr_reads", 32'(rd2_n - b2), 32'd2);
      check("t5_rx0", 32'(rxv[0]), 32'h5A);
      check("t5_rx1", 32'(rxv[1]), 32'hC3);
      check("t5_wb_stable", 32'(stab_err), 32'd0);
      ack_dly = 0;

      // T6: reset during the SPSR poll of byte 2, then a normal transaction
      base = wr_n;
      txv[0] = 8'h10; txv[1] = 8'h20; txv[2] = 8'h30;
      send_req(8'd3, 1'b0, 1'b0, 4'h0, 1'b1);
      fork tx_feed(2, 0); rx_take(1, 0); join
      begin
         int k = 0;
         while (!(wb_cyc === 1'b1 && wb_adr === 3'd1 && wb_we === 1'b0) && k < LIMIT) begin
            @(negedge clk); k++;
         end
         check("t6_poll_reached", 32'(wb_cyc), 32'd1);
      end
      check("t6_wr_before_rst", 32'(wr_n - base), 32'd5);
      #2 rstn = 1'b0;
      #1;
      check("t6_rst_cyc", 32'({wb_cyc, wb_stb}), 32'd0);
      check("t6_rst_rx_valid", 32'(rx_valid), 32'd0);
      repeat (2) @(negedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
      check("t6_req_ready", 32'(req_ready), 32'd1);

      loop_mode = 1'b0; echo_val = 8'h3C;
      base = wr_n;
      txv[0] = 8'h11;
      send_req(8'd1, 1'b0, 1'b0, 4'h0, 1'b1);
      fork tx_feed(1, 0); rx_take(1, 0); wait_done(); join
      ew[0] = {3'd0, 8'h50}; ew[1] = {3'd3, 8'h00}; ew[2] = {3'd4, 8'h01};
      ew[3] = {3'd2, 8'h11}; ew[4] = {3'd4, 8'h00}; ew[5] = {3'd0, 8'h00};
      check_writes("t6b", base, 6);
      check("t6b_rx", 32'(rxv[0]), 32'h3C);
      check("t6b_err", 32'(d_err), 32'd0);

      repeat (2) @(negedge clk);
      check("wb_stable_total", 32'(stab_err), 32'd0);
      check("wb_idle_gap_total", 32'(b2b_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
